compare_flag_gen: RTL and testbench
===================================

# compare_flag_gen

Multi-cycle flag generator feeding the comparison unit of the Part 2 MIPS datapath. It computes A − B as A + ~B + 1, CHUNK bits per cycle. It produces the carry, zero and difference-sign flags plus both operand sign bits, along with the opcode latched with the operands. A start/busy/done handshake lets the controller stall until the flags are valid.

## Interface
Parameters:
- WIDTH, 32, operand width.
- CHUNK, 8, bits processed per cycle. Must divide WIDTH; WIDTH = CHUNK is legal.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- operand_a  input  WIDTH  A, latched on an accepted start.
- operand_b  input  WIDTH  B, latched on an accepted start.
- opcode_in  input  3  comparison opcode, latched on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the flags become valid.
- flags_valid  output  1  level; high from done until the next accepted start.
- carry_flag  output  1  final carry-out; 1 means A ≥ B unsigned.
- zero_flag  output  1  1 when (A − B) mod 2^WIDTH = 0.
- diff  output  1  MSB of A − B.
- a_sign  output  1  operand_a[WIDTH-1] as latched.
- b_sign  output  1  operand_b[WIDTH-1] as latched.
- opcode_out  output  3  latched opcode, held with the flags.

## Operation
- States: IDLE, RUN.
- IDLE with start=1:
  - latch operand_a, operand_b and opcode_in;
  - chunk index = 0, running carry = 1, running zero = 1;
  - clear flags_valid; go to RUN.
- RUN, each cycle, process chunk k (bits k·CHUNK … k·CHUNK+CHUNK−1):
  - sum = A_k + ~B_k + carry;
  - carry = carry-out of that sum;
  - zero = zero AND (sum bits == 0).
- RUN on the last chunk (k = WIDTH/CHUNK − 1):
  - register carry_flag, zero_flag, diff = top bit of the last sum, a_sign, b_sign and opcode_out;
  - assert done and flags_valid; return to IDLE.
- start while in RUN is ignored; there is no queueing.
- Outputs hold their values until the next accepted start. On that start, flags_valid falls; the flag values are don't-care until the next done.
- Reset (asynchronous, at any time, including mid-RUN):
  - state returns to IDLE; the partial computation is discarded;
  - busy, done, flags_valid, all flags, opcode_out and the chunk index go to 0.
- The operand registers are internal. Operand input changes after acceptance have no effect.

## Timing
- N = WIDTH/CHUNK. Start is accepted at edge E0.
- busy is high for the N cycles following E0.
- Flags register at edge EN. done is high for exactly the single cycle after EN.
- Latency from the start edge to flags valid is N cycles: 4 with the defaults, 1 when CHUNK = WIDTH.
- Start asserted in the done cycle is accepted, because the block is in IDLE. Maximum throughput is one operation per N+1 cycles.
- No combinational path from inputs to outputs.

## Structure
- A shared package holds:
  - the state enum (IDLE, RUN);
  - the 3-bit comparison opcode constants used by the comparison unit (001 = signed ≥, 010 = signed <, 011 = ≠, 100 = ==, 101 = unsigned ≥, 110 = unsigned <).
- Sub-module chunk_subtractor (combinational, parameter CHUNK):
  - inputs a, b, cin;
  - outputs sum, cout, and zero (sum bits all 0).
- The top level contains the FSM, the counter and the registers.

## Test plan
- A=5, B=5, opcode 100 → after 4 cycles, one-cycle done; carry=1, zero=1, diff=0, opcode_out=100.
- A=3, B=7 (difference 0xFFFFFFFC) → carry=0, zero=0, diff=1, a_sign=0, b_sign=0.
- A=0x80000000, B=1 (difference 0x7FFFFFFF) → carry=1, zero=0, diff=0, a_sign=1, b_sign=0.
- Start pulses in each RUN cycle with different operands → ignored; the result matches the first operands, and busy lasts exactly 4 cycles.
- rst asserted in the 2nd RUN cycle → all outputs 0 immediately (asynchronous); after release, a new start computes A=0xFFFFFFFF, B=0 correctly: carry=1, zero=0, diff=1.
- CHUNK=32 instance, A=0, B=1 → done 1 cycle after start; carry=0, diff=1. Back-to-back start in the done cycle is accepted.

Source files
------------

// File: rtl/compare_flag_gen_pkg.sv
// Shared types and constants for the comparison flag generator and its consumer.
package compare_flag_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Comparison opcodes interpreted by the downstream comparison unit.
  localparam logic [2:0] OPC_SGE = 3'b001;
  localparam logic [2:0] OPC_SLT = 3'b010;
  localparam logic [2:0] OPC_NE  = 3'b011;
  localparam logic [2:0] OPC_EQ  = 3'b100;
  localparam logic [2:0] OPC_UGE = 3'b101;
  localparam logic [2:0] OPC_ULT = 3'b110;

  function automatic logic opcodeValid(input logic [2:0] opc);
    return (opc == OPC_SGE) || (opc == OPC_SLT) || (opc == OPC_NE) ||
           (opc == OPC_EQ)  || (opc == OPC_UGE) || (opc == OPC_ULT);
  endfunction

endpackage

// File: rtl/compare_flag_gen_chunk_subtractor.sv
// One CHUNK-wide slice of A + ~B + cin, with carry-out and all-zero detect.
module chunk_subtractor #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             zero
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, ~b} + {{CHUNK{1'b0}}, cin};
    zero        = (sum == '0);
  end

endmodule

// File: rtl/compare_flag_gen.sv
// Multi-cycle A - B flag generator: one CHUNK slice per cycle, start/busy/done handshake.
module compare_flag_gen
  import compare_flag_gen_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [2:0]       opcode_in,
  output logic             busy,
  output logic             done,
  output logic             flags_valid,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             diff,
  output logic             a_sign,
  output logic             b_sign,
  output logic [2:0]       opcode_out
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t            state, stateNext;
  logic [WIDTH-1:0]  aReg, bReg;
  logic [IDXW-1:0]   chunkIdx;
  logic              runCarry, runZero;
  logic [2:0]        opcodeLat;
  logic [CHUNK-1:0]  chunkSum;
  logic              chunkCout, chunkZero;
  logic              lastChunk;

  // Operands shift right each cycle, so the active chunk is always in the low bits
  // and on the last chunk the low slice holds the original top bits (sign included).
  chunk_subtractor #(.CHUNK(CHUNK)) uSub (
    .a    (aReg[CHUNK-1:0]),
    .b    (bReg[CHUNK-1:0]),
    .cin  (runCarry),
    .sum  (chunkSum),
    .cout (chunkCout),
    .zero (chunkZero)
  );

  assign lastChunk = (chunkIdx == LAST_IDX);
  assign busy      = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start)     stateNext = RUN;
      RUN:     if (lastChunk) stateNext = IDLE;
      default:                stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aReg        <= '0;
      bReg        <= '0;
      chunkIdx    <= '0;
      runCarry    <= 1'b0;
      runZero     <= 1'b0;
      opcodeLat   <= '0;
      done        <= 1'b0;
      flags_valid <= 1'b0;
      carry_flag  <= 1'b0;
      zero_flag   <= 1'b0;
      diff        <= 1'b0;
      a_sign      <= 1'b0;
      b_sign      <= 1'b0;
      opcode_out  <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        aReg        <= operand_a;
        bReg        <= operand_b;
        opcodeLat   <= opcode_in;
        chunkIdx    <= '0;
        runCarry    <= 1'b1;
        runZero     <= 1'b1;
        flags_valid <= 1'b0;
      end else if (state == RUN) begin
        aReg     <= aReg >> CHUNK;
        bReg     <= bReg >> CHUNK;
        runCarry <= chunkCout;
        runZero  <= runZero & chunkZero;
        chunkIdx <= chunkIdx + 1'b1;
        if (lastChunk) begin
          chunkIdx    <= '0;
          carry_flag  <= chunkCout;
          zero_flag   <= runZero & chunkZero;
          diff        <= chunkSum[CHUNK-1];
          a_sign      <= aReg[CHUNK-1];
          b_sign      <= bReg[CHUNK-1];
          opcode_out  <= opcodeLat;
          done        <= 1'b1;
          flags_valid <= 1'b1;
        end
      end
    end
  end

  zeroDetectConsistent: assert property (@(posedge clk) disable iff (rst)
    chunkZero == (chunkSum == '0));

endmodule

// File: tb/tb_compare_flag_gen.sv
// Bench for compare_flag_gen: 32/8 and 32/32 instances checked each cycle against an edge-counting model.
module tb_compare_flag_gen;
  import compare_flag_gen_pkg::*;

  logic        clk, rst;
  logic        start [2];
  logic [31:0] opA [2], opB [2];
  logic [2:0]  opc [2];
  logic        busy [2], done [2], fv [2], cf [2], zf [2], df [2], as [2], bs [2];
  logic [2:0]  oo [2];

  int checks = 0;
  int errors = 0;

  compare_flag_gen #(.WIDTH(32), .CHUNK(8)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .operand_a(opA[0]), .operand_b(opB[0]),
    .opcode_in(opc[0]), .busy(busy[0]), .done(done[0]), .flags_valid(fv[0]),
    .carry_flag(cf[0]), .zero_flag(zf[0]), .diff(df[0]), .a_sign(as[0]), .b_sign(bs[0]),
    .opcode_out(oo[0]));

  compare_flag_gen #(.WIDTH(32), .CHUNK(32)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .operand_a(opA[1]), .operand_b(opB[1]),
    .opcode_in(opc[1]), .busy(busy[1]), .done(done[1]), .flags_valid(fv[1]),
    .carry_flag(cf[1]), .zero_flag(zf[1]), .diff(df[1]), .a_sign(as[1]), .b_sign(bs[1]),
    .opcode_out(oo[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an op accepted at edge e publishes its flags at edge e+N; until then the block is busy.
  int          nChunks [2] = '{4, 1};
  int          edgeNo = 0;
  int          accEdge [2] = '{-100, -100};
  int          doneEdge [2] = '{-100, -100};
  bit          pend [2] = '{0, 0};
  bit          eValid [2] = '{0, 0};
  bit          eKnown [2] = '{1, 1};
  logic [31:0] pA [2], pB [2];
  logic [2:0]  pOp [2];
  logic        eC [2] = '{0, 0}, eZ [2] = '{0, 0}, eD [2] = '{0, 0};
  logic        eAs [2] = '{0, 0}, eBs [2] = '{0, 0};
  logic [2:0]  eOp [2] = '{3'd0, 3'd0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        pend[u] = 0; eValid[u] = 0; eKnown[u] = 1; doneEdge[u] = -100;
        eC[u] = 0; eZ[u] = 0; eD[u] = 0; eAs[u] = 0; eBs[u] = 0; eOp[u] = '0;
      end
    end else begin
      edgeNo++;
      for (int u = 0; u < 2; u++) begin
        if (pend[u] && edgeNo == accEdge[u] + nChunks[u]) begin
          logic [31:0] d;
          d        = pA[u] - pB[u];
          eC[u]    = (pA[u] >= pB[u]);
          eZ[u]    = (pA[u] == pB[u]);
          eD[u]    = d[31];
          eAs[u]   = pA[u][31];
          eBs[u]   = pB[u][31];
          eOp[u]   = pOp[u];
          pend[u]  = 0;
          eValid[u] = 1;
          eKnown[u] = 1;
          doneEdge[u] = edgeNo;
        end else if (!pend[u] && start[u]) begin
          pA[u] = opA[u]; pB[u] = opB[u]; pOp[u] = opc[u];
          accEdge[u] = edgeNo;
          pend[u] = 1;
          eValid[u] = 0;
          eKnown[u] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d busy", u), 32'(busy[u]), 32'(pend[u]));
      chk($sformatf("u%0d done", u), 32'(done[u]), 32'(doneEdge[u] == edgeNo));
      chk($sformatf("u%0d flags_valid", u), 32'(fv[u]), 32'(eValid[u]));
      if (eKnown[u]) begin
        chk($sformatf("u%0d carry", u), 32'(cf[u]), 32'(eC[u]));
        chk($sformatf("u%0d zero", u), 32'(zf[u]), 32'(eZ[u]));
        chk($sformatf("u%0d diff", u), 32'(df[u]), 32'(eD[u]));
        chk($sformatf("u%0d a_sign", u), 32'(as[u]), 32'(eAs[u]));
        chk($sformatf("u%0d b_sign", u), 32'(bs[u]), 32'(eBs[u]));
        chk($sformatf("u%0d opcode_out", u), 32'(oo[u]), 32'(eOp[u]));
      end
    end
  end

  function automatic logic [2:0] randOpc();
    logic [2:0] tbl [6];
    tbl = '{OPC_SGE, OPC_SLT, OPC_NE, OPC_EQ, OPC_UGE, OPC_ULT};
    return tbl[$urandom_range(0, 5)];
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic runOp(input int u, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input bit spam, input int expN,
                       input logic xC, input logic xZ, input logic xD,
                       input logic xAs, input logic xBs);
    int busyCnt = 0;
    int lat = 0;
    start[u] = 1'b1; opA[u] = a; opB[u] = b; opc[u] = op;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done[u]) begin
        lat = i;
        start[u] = 1'b0;
        break;
      end
      if (busy[u]) busyCnt++;
      start[u] = spam;
      opA[u] = $urandom; opB[u] = $urandom; opc[u] = randOpc();
    end
    chk($sformatf("u%0d latency", u), 32'(lat), 32'(expN + 1));
    chk($sformatf("u%0d busy cycles", u), 32'(busyCnt), 32'(expN));
    chk($sformatf("u%0d lit flags_valid", u), 32'(fv[u]), 32'd1);
    chk($sformatf("u%0d lit carry", u), 32'(cf[u]), 32'(xC));
    chk($sformatf("u%0d lit zero", u), 32'(zf[u]), 32'(xZ));
    chk($sformatf("u%0d lit diff", u), 32'(df[u]), 32'(xD));
    chk($sformatf("u%0d lit a_sign", u), 32'(as[u]), 32'(xAs));
    chk($sformatf("u%0d lit b_sign", u), 32'(bs[u]), 32'(xBs));
    chk($sformatf("u%0d lit opcode", u), 32'(oo[u]), 32'(op));
  endtask

  function automatic logic [31:0] pickOperand(input int mode);
    logic [31:0] edges [4];
    edges = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case (mode)
      1:       return 32'($urandom_range(0, 15));
      3:       return edges[$urandom_range(0, 3)];
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      start[u] = 1'b0; opA[u] = '0; opB[u] = '0; opc[u] = '0;
    end
    @(negedge clk);
    chk("reset busy", 32'(busy[0]), 32'd0);
    chk("reset flags_valid", 32'(fv[0]), 32'd0);
    chk("reset opcode_out", 32'(oo[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    runOp(0, 32'd5, 32'd5, OPC_EQ, 0, 4, 1, 1, 0, 0, 0);
    runOp(0, 32'd3, 32'd7, OPC_SLT, 0, 4, 0, 0, 1, 0, 0);
    runOp(0, 32'h8000_0000, 32'd1, OPC_SGE, 0, 4, 1, 0, 0, 1, 0);
    @(negedge clk);
    runOp(0, 32'h0000_1234, 32'h0000_1234, OPC_NE, 1, 4, 1, 1, 0, 0, 0);
    @(negedge clk);

    // Asynchronous reset landing in the second RUN cycle.
    start[0] = 1'b1; opA[0] = 32'h1111_2222; opB[0] = 32'h0000_0001; opc[0] = OPC_UGE;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrun rst busy", 32'(busy[0]), 32'd0);
    chk("midrun rst done", 32'(done[0]), 32'd0);
    chk("midrun rst flags_valid", 32'(fv[0]), 32'd0);
    chk("midrun rst flags", {27'd0, cf[0], zf[0], df[0], as[0], bs[0]}, 32'd0);
    chk("midrun rst opcode", 32'(oo[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    runOp(0, 32'hFFFF_FFFF, 32'd0, OPC_UGE, 0, 4, 1, 0, 1, 1, 0);

    runOp(1, 32'd0, 32'd1, OPC_ULT, 0, 1, 0, 0, 1, 0, 0);
    runOp(1, 32'd7, 32'd3, OPC_UGE, 0, 1, 1, 0, 0, 0, 0);
    runOp(1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, OPC_EQ, 0, 1, 1, 1, 0, 1, 1);
    chk("opcode table", 32'(opcodeValid(oo[1])), 32'd1);

    repeat (600) begin
      @(negedge clk);
      if ($urandom_range(0, 149) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      for (int u = 0; u < 2; u++) begin
        int mode;
        mode = $urandom_range(0, 3);
        start[u] = ($urandom_range(0, 2) == 0);
        opA[u] = pickOperand(mode);
        opB[u] = (mode == 0) ? opA[u] : pickOperand(mode);
        opc[u] = randOpc();
      end
    end
    for (int u = 0; u < 2; u++) start[u] = 1'b0;
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
